// File: rtl/data_decimator_mc_pkg.sv
// rtl/data_decimator_mc_pkg.sv - shared modes and arithmetic helpers for the ADC decimator
package data_decimation_pkg;

    localparam logic [1:0] MODE_KEEP_LAST = 2'd0;
    localparam logic [1:0] MODE_AVERAGE   = 2'd1;
    localparam logic [1:0] MODE_PEAK      = 2'd2;

    // Wide enough to sum 2^dec_w full-scale samples without overflow.
    function automatic int acc_width(input int in_w, input int dec_w);
        return in_w + dec_w;
    endfunction

    function automatic logic [63:0] saturate(input logic [63:0] value, input int out_w);
        logic [63:0] max_val;
        if (out_w >= 64) begin
            return value;
        end
        max_val = (64'd1 << out_w) - 64'd1;
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/data_decimator_mc_lane.sv
// rtl/data_decimator_mc_lane.sv - one lane: accumulator, mode update and output saturation
module decim_lane
    import data_decimation_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int DEC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic             first,
    input  logic [1:0]       mode,
    input  logic [4:0]       shift,
    input  logic [IN_W-1:0]  sample,
    output logic [OUT_W-1:0] result
);

    localparam int ACC_W = acc_width(IN_W, DEC_W);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] shifted;
    logic [63:0]      wide;

    // result reflects the beat being accepted, so the top can load it on the closing edge
    always_comb begin
        sample_ext = ACC_W'(sample);
        acc_next   = sample_ext;
        if (!first) begin
            case (mode)
                MODE_AVERAGE: acc_next = acc_q + sample_ext;
                MODE_PEAK:    acc_next = (sample_ext > acc_q) ? sample_ext : acc_q;
                default:      acc_next = sample_ext;
            endcase
        end
        shifted = (mode == MODE_AVERAGE) ? (acc_next >> shift) : acc_next;
        wide    = 64'(shifted);
        result  = OUT_W'(saturate(wide, OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_next;
        end
    end

endmodule

// File: rtl/data_decimator_mc.sv
// rtl/data_decimator_mc.sv - multi-channel windowed decimator with backpressure and framing
module data_decimator_mc
    import data_decimation_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 12,
    parameter int DATA_OUT_WIDTH = 16,
    parameter int NUM_CH         = 2,
    parameter int DEC_WIDTH      = 16,
    parameter int FRAME_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [DEC_WIDTH-1:0]             decimate_reg,
    input  logic [1:0]                       mode_reg,
    input  logic [4:0]                       shift_reg,
    input  logic [FRAME_WIDTH-1:0]           frame_len_reg,
    input  logic [NUM_CH*DATA_IN_WIDTH-1:0]  in_data,
    input  logic                             in_data_valid,
    output logic                             in_data_ready,
    output logic [NUM_CH*DATA_OUT_WIDTH-1:0] out_data,
    output logic                             out_data_valid,
    input  logic                             out_data_ready,
    output logic                             out_data_last,
    output logic [31:0]                      window_cnt
);

    logic                             run_q;
    logic [DEC_WIDTH-1:0]             cnt_q;
    logic [DEC_WIDTH-1:0]             dec_q;
    logic [1:0]                       mode_q;
    logic [4:0]                       shift_q;
    logic [FRAME_WIDTH-1:0]           fcnt_q;
    logic [NUM_CH*DATA_OUT_WIDTH-1:0] results;

    logic                 first;
    logic                 accept;
    logic                 close;
    logic                 handoff;
    logic [DEC_WIDTH-1:0] dec_eff;
    logic [1:0]           mode_eff;
    logic [4:0]           shift_eff;

    assign in_data_ready = run_q && enable && (!out_data_valid || out_data_ready);
    assign accept        = in_data_valid && in_data_ready;
    assign handoff       = out_data_valid && out_data_ready;
    assign first         = (cnt_q == '0);

    // The opening beat of a window uses the live config, which is latched alongside it.
    assign dec_eff   = first ? decimate_reg : dec_q;
    assign mode_eff  = first ? mode_reg     : mode_q;
    assign shift_eff = first ? shift_reg    : shift_q;
    assign close     = accept && (cnt_q == dec_eff);

    assign out_data_last = out_data_valid && (fcnt_q == frame_len_reg);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        decim_lane #(
            .IN_W  (DATA_IN_WIDTH),
            .OUT_W (DATA_OUT_WIDTH),
            .DEC_W (DEC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (!enable),
            .accept (accept),
            .first  (first),
            .mode   (mode_eff),
            .shift  (shift_eff),
            .sample (in_data[k*DATA_IN_WIDTH +: DATA_IN_WIDTH]),
            .result (results[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            dec_q   <= '0;
            mode_q  <= MODE_KEEP_LAST;
            shift_q <= '0;
        end else begin
            run_q <= 1'b1;
            if (!enable) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= close ? '0 : cnt_q + 1'b1;
                if (first) begin
                    dec_q   <= decimate_reg;
                    mode_q  <= mode_reg;
                    shift_q <= shift_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data       <= '0;
            out_data_valid <= 1'b0;
            fcnt_q         <= '0;
            window_cnt     <= '0;
        end else begin
            if (close) begin
                out_data       <= results;
                out_data_valid <= 1'b1;
            end else if (handoff) begin
                out_data_valid <= 1'b0;
            end
            if (handoff) begin
                fcnt_q     <= (fcnt_q == frame_len_reg) ? '0 : fcnt_q + 1'b1;
                window_cnt <= window_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/data_decimator_mc.md
# data_decimator_mc

Multi-channel, parametrised decimator for the ADC capture path, placed between the ADC sample stream and the AXI-Stream DMA packer. Each input beat carries NUM_CH packed samples. Every window of decimate_reg+1 accepted beats yields one output beat per window, using one of three modes: keep-last, sum-and-shift average, or peak. It provides full valid/ready backpressure, a registered output and optional frame marking with out_data_last.

## Interface
- DATA_IN_WIDTH, 12: width of one unsigned (offset-binary) input sample.
- DATA_OUT_WIDTH, 16: width of one output sample.
- NUM_CH, 2: lanes per beat. Lane k occupies bits [k*W+W-1 : k*W].
- DEC_WIDTH, 16: width of the decimation count. The accumulator is DATA_IN_WIDTH+DEC_WIDTH bits.
- FRAME_WIDTH, 16: width of frame_len_reg.
- clk, input, 1: single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: run when high. When low, flush the window and block input.
- decimate_reg, input, DEC_WIDTH: window length minus 1. A value of 0 means pass-through.
- mode_reg, input, 2: 0 = KEEP_LAST, 1 = AVERAGE, 2 = PEAK. 3 is reserved and behaves as KEEP_LAST.
- shift_reg, input, 5: right shift applied to the sum in AVERAGE mode.
- frame_len_reg, input, FRAME_WIDTH: outputs per frame minus 1.
- in_data, input, NUM_CH*DATA_IN_WIDTH: packed samples.
- in_data_valid, input, 1: input beat valid.
- in_data_ready, output, 1: input beat accepted when high together with in_data_valid.
- out_data, output, NUM_CH*DATA_OUT_WIDTH: packed results.
- out_data_valid, output, 1: output beat valid.
- out_data_ready, input, 1: downstream ready.
- out_data_last, output, 1: high on the last beat of each frame.
- window_cnt, output, 32: count of output beats handed off, wraps.

## Operation
- Acceptance:
  - A beat is accepted on a clock edge when in_data_valid and in_data_ready are both high.
  - in_data_ready = run_q && enable && (!out_data_valid || out_data_ready).
  - run_q is a flag cleared by reset and set on the first clock after reset release.
- Config latch: decimate_reg, mode_reg and shift_reg are captured when the first beat of a window is accepted (cnt==0). Changes mid-window take effect from the next window.
- Per-lane update, per accepted beat:
  - First beat (cnt==0): acc = sample.
  - Later beats:
    - KEEP_LAST: acc = sample.
    - AVERAGE: acc = acc + sample.
    - PEAK: acc = max(acc, sample), unsigned compare.
- Window close:
  - When the accepted beat has cnt == dec_latched, cnt returns to 0 and the output register is loaded. Otherwise cnt increments.
  - AVERAGE result: (acc+sample) >> shift_latched.
  - Output width: the result is saturated to 2^DATA_OUT_WIDTH−1 if wider, and zero-extended if narrower.
- Output register:
  - Holds data, valid and last stable while out_data_valid && !out_data_ready.
  - Clears valid on handoff unless a new window closes in the same cycle.
- Framing:
  - fcnt counts handed-off beats.
  - out_data_last = (fcnt == frame_len_reg). fcnt wraps to 0 after the last beat.
  - frame_len_reg is sampled live.
- enable low:
  - in_data_ready goes to 0.
  - cnt and acc clear on the next edge and the partial window is discarded.
  - A pending output beat is still delivered.
  - fcnt is retained.
- Reset (asynchronous, any time):
  - All state clears immediately.
  - out_data=0, out_data_valid=0, out_data_last=0 (fcnt=0), in_data_ready=0, window_cnt=0, cnt=0, acc=0.
  - An in-flight beat is lost.

## Timing
- Latency: out_data_valid rises 1 clk after the edge that accepts the window's closing beat.
- Throughput:
  - One input beat per clock while the output is drained.
  - decimate_reg=0 with out_data_ready held high gives one output per clock, no bubbles.
- Backpressure: while out_data_valid && !out_data_ready, in_data_ready is 0. No sample is dropped.
- Simultaneous handoff and close: the new beat loads in the same cycle and valid stays 1.
- cnt and acc never overflow: the maximum sum (2^DATA_IN_WIDTH−1)·2^DEC_WIDTH fits the accumulator.

## Structure
- Package data_decimation_pkg holds:
  - mode localparams MODE_KEEP_LAST=2'd0, MODE_AVERAGE=2'd1, MODE_PEAK=2'd2;
  - an ACC_WIDTH function;
  - a saturation function.
- Sub-module decim_lane: one lane's accumulator, mode update and output saturation, instantiated NUM_CH times by a generate loop.
- Top level: the counter, config latch, handshake, output register and framing.

## Test plan
- Pass-through: decimate_reg=0, KEEP_LAST, NUM_CH=2, ramp 0..9 on both lanes, out_data_ready=1 → 10 outputs equal to the inputs, each 1 clk later, no gaps.
- AVERAGE: decimate_reg=3, shift_reg=2, lane0 inputs 4,8,12,16 → lane0 output 10; lane1 constant 4095 → 4095.
- PEAK with stall: decimate_reg=4, lane0 inputs 3,900,7,899,1, out_data_ready low for 5 clks at the close → out holds 900 stable, in_data_ready=0 throughout, no input lost.
- Config change mid-window: decimate_reg switched 3→1 after the 2nd beat → current window still closes at beat 4, the next at 2 beats.
- Framing: frame_len_reg=2, 7 outputs → out_data_last high on outputs 3 and 6; window_cnt=7.
- Reset and enable: assert rst_n low mid-window with out_data_valid=1 → all outputs 0 at once. Drop enable after 2 of 4 beats → partial window discarded and the next output is built only from beats accepted after enable returns.
